// File: rtl/rst_seq_pkg.sv
`default_nettype none
//==== rst_seq_pkg : reset-sequencer state encoding, stage indices, helpers (rev 1.0) ====
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_CFG_REL   = 3'd1,
    ST_DDR_REL   = 3'd2,
    ST_WAIT_CAL  = 3'd3,
    ST_SYS_REL   = 3'd4,
    ST_CORE_REL  = 3'd5,
    ST_RUN       = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  localparam int STG_CFG  = 0;
  localparam int STG_DDR  = 1;
  localparam int STG_SYS  = 2;
  localparam int STG_CORE = 3;
  localparam int NUM_STG  = 4;

  // Retry limit saturated into the 2-bit retry counter range.
  function automatic logic [1:0] retry_limit(input int max_retry);
    if (max_retry < 0) return 2'd0;
    if (max_retry > 3) return 2'd3;
    return 2'(max_retry);
  endfunction

  // Stages whose reset is released while sitting in state s.
  function automatic logic [NUM_STG-1:0] rel_mask(input state_t s);
    logic [NUM_STG-1:0] m;
    m = '0;
    case (s)
      ST_DDR_REL:              m[STG_CFG] = 1'b1;
      ST_WAIT_CAL, ST_SYS_REL: m[STG_DDR:STG_CFG] = '1;
      ST_CORE_REL:             m[STG_SYS:STG_CFG] = '1;
      ST_RUN:                  m = '1;
      default:                 m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_lock_filter.sv
`default_nettype none
//==== rst_lock_filter : PLL-lock debounce, LOCK_FILT consecutive highs -> lock_stable (rev 1.0) ====
module rst_lock_filter #(
  parameter int LOCK_FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic lock_stable
);

  localparam int CW = $clog2(LOCK_FILT + 1);
  localparam logic [CW-1:0] LIM = CW'(LOCK_FILT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = (cnt == LIM) ? LIM : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      lock_stable <= 1'b0;
    end else if (!pll_locked) begin
      cnt         <= '0;
      lock_stable <= 1'b0;
    end else begin
      cnt         <= cnt_inc;
      lock_stable <= (cnt_inc == LIM);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
//==== rst_seq_ctrl : ordered DDR-cfg/DDR/sys/core reset release with cal retry (rev 1.0) ====
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int STAGE_WAIT  = 100,
  parameter int CAL_TIMEOUT = 50000,
  parameter int LOCK_FILT   = 8,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 16
) (
  input  logic       CLK_25M,
  input  logic       RST,
  input  logic       i_pll_locked,
  input  logic       i_ddr_init_done,
  input  logic       i_soft_rst_req,
  output logic       o_ddr_cfg_rstn,
  output logic       o_ddr_rstn,
  output logic       o_sys_rstn,
  output logic       o_core_reset,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_fail,
  output logic [1:0] o_retry_cnt,
  output logic [2:0] o_state
);

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_WAIT - 1);
  localparam logic [CNT_W-1:0] CAL_LAST   = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_LIM  = retry_limit(MAX_RETRY);

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         retry_cnt, retry_nxt;
  logic [NUM_STG-1:0] rel;
  logic               ready, busy, fail;
  logic               lock_stable;
  logic               retry_req;
  logic               waiting;

  rst_lock_filter #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filter (
    .clk         (CLK_25M),
    .rst         (RST),
    .pll_locked  (i_pll_locked),
    .lock_stable (lock_stable)
  );

  assign waiting = (state == ST_CFG_REL) || (state == ST_DDR_REL) || (state == ST_WAIT_CAL) ||
                   (state == ST_SYS_REL) || (state == ST_CORE_REL);

  always_comb begin
    nxt_state = state;
    retry_nxt = retry_cnt;
    retry_req = 1'b0;
    if (state == ST_FAIL) begin
      nxt_state = ST_FAIL;
    end else if (!lock_stable && (state != ST_WAIT_LOCK)) begin
      nxt_state = ST_WAIT_LOCK;
    end else if (i_soft_rst_req) begin
      nxt_state = ST_WAIT_LOCK;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_WAIT_LOCK: if (lock_stable) nxt_state = ST_CFG_REL;
        ST_CFG_REL:   if (cnt == STAGE_LAST) nxt_state = ST_DDR_REL;
        ST_DDR_REL:   if (cnt == STAGE_LAST) nxt_state = ST_WAIT_CAL;
        // done is checked ahead of the timeout so a same-cycle rise wins
        ST_WAIT_CAL: begin
          if (i_ddr_init_done)      nxt_state = ST_SYS_REL;
          else if (cnt == CAL_LAST) retry_req = 1'b1;
        end
        ST_SYS_REL: begin
          if (!i_ddr_init_done)       retry_req = 1'b1;
          else if (cnt == STAGE_LAST) nxt_state = ST_CORE_REL;
        end
        ST_CORE_REL: begin
          if (!i_ddr_init_done)       retry_req = 1'b1;
          else if (cnt == STAGE_LAST) nxt_state = ST_RUN;
        end
        ST_RUN:  if (!i_ddr_init_done) retry_req = 1'b1;
        default: nxt_state = state;
      endcase
      if (retry_req) begin
        if (retry_cnt == RETRY_LIM) begin
          nxt_state = ST_FAIL;
        end else begin
          nxt_state = ST_WAIT_LOCK;
          retry_nxt = retry_cnt + 2'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    if ((nxt_state == state) && waiting) cnt_nxt = cnt + 1'b1;
  end

  // Output registers follow the next state so they change on the same edge as o_state.
  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      state     <= ST_WAIT_LOCK;
      cnt       <= '0;
      retry_cnt <= '0;
      rel       <= '0;
      ready     <= 1'b0;
      busy      <= 1'b1;
      fail      <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      rel       <= rel_mask(nxt_state);
      ready     <= (nxt_state == ST_RUN);
      busy      <= (nxt_state != ST_RUN) && (nxt_state != ST_FAIL);
      fail      <= (nxt_state == ST_FAIL);
    end
  end

  assign o_ddr_cfg_rstn = rel[STG_CFG];
  assign o_ddr_rstn     = rel[STG_DDR];
  assign o_sys_rstn     = rel[STG_SYS];
  assign o_core_reset   = ~rel[STG_CORE];
  assign o_ready        = ready;
  assign o_busy         = busy;
  assign o_fail         = fail;
  assign o_retry_cnt    = retry_cnt;
  assign o_state        = state;

endmodule
`default_nettype wire
